// File: rtl/dsp_share_arb.sv
// Round-robin arbiter sharing one pipelined DSP slice (P = (B+D)*A + C) between NREQ requesters.
// A tag pipeline follows each issued operand set so its DSP result is routed back to the owner.
module dsp_share_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*18-1:0]   req_a,
    input  logic [NREQ*18-1:0]   req_b,
    input  logic [NREQ*18-1:0]   req_d,
    input  logic [NREQ*48-1:0]   req_c,
    output logic [17:0]          dsp_a,
    output logic [17:0]          dsp_b,
    output logic [17:0]          dsp_d,
    output logic [47:0]          dsp_c,
    input  logic [47:0]          dsp_p,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [47:0]          rsp_p,
    output logic [3:0]           inflight
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  grantIdx;
    logic            grantHit;

    logic [17:0]     dspA_q, dspA_d;
    logic [17:0]     dspB_q, dspB_d;
    logic [17:0]     dspD_q, dspD_d;
    logic [47:0]     dspC_q, dspC_d;

    logic [LATENCY:0] tagValid_q, tagValid_d;
    logic [IDW-1:0]   tagId_q [LATENCY+1];
    logic [IDW-1:0]   tagId_d [LATENCY+1];

    logic [NREQ-1:0] rspValid_q, rspValid_d;
    logic [47:0]     rspP_q, rspP_d;
    logic [3:0]      inflight_q, inflight_d;

    // Search starts just after the last winner; reset also blocks grants so nothing is accepted then.
    always_comb begin
        grantHit  = 1'b0;
        grantIdx  = '0;
        cand      = '0;
        req_ready = '0;
        if (rst_n && arb_en) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((int'(ptr_q) + k) % NREQ);
                if (!grantHit && req_valid[cand]) begin
                    grantHit = 1'b1;
                    grantIdx = cand;
                end
            end
        end
        if (grantHit) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        dspA_d     = dspA_q;
        dspB_d     = dspB_q;
        dspD_d     = dspD_q;
        dspC_d     = dspC_q;
        tagValid_d = {tagValid_q[LATENCY-1:0], grantHit};
        tagId_d[0] = grantIdx;
        for (int k = 1; k <= LATENCY; k++) begin
            tagId_d[k] = tagId_q[k-1];
        end
        if (grantHit) begin
            ptr_d  = grantIdx;
            dspA_d = req_a[18*grantIdx +: 18];
            dspB_d = req_b[18*grantIdx +: 18];
            dspD_d = req_d[18*grantIdx +: 18];
            dspC_d = req_c[48*grantIdx +: 48];
        end

        // The last tag stage lines up with the DSP result for that same operation.
        rspValid_d = '0;
        rspP_d     = rspP_q;
        if (tagValid_q[LATENCY]) begin
            rspValid_d[tagId_q[LATENCY]] = 1'b1;
            rspP_d                       = dsp_p;
        end

        inflight_d = inflight_q;
        case ({grantHit, |rspValid_q})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IDW'(NREQ - 1);
            dspA_q     <= '0;
            dspB_q     <= '0;
            dspD_q     <= '0;
            dspC_q     <= '0;
            tagValid_q <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tagId_q[k] <= '0;
            end
            rspValid_q <= '0;
            rspP_q     <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            dspA_q     <= dspA_d;
            dspB_q     <= dspB_d;
            dspD_q     <= dspD_d;
            dspC_q     <= dspC_d;
            tagValid_q <= tagValid_d;
            for (int k = 0; k <= LATENCY; k++) begin
                tagId_q[k] <= tagId_d[k];
            end
            rspValid_q <= rspValid_d;
            rspP_q     <= rspP_d;
            inflight_q <= inflight_d;
        end
    end

    assign dsp_a     = dspA_q;
    assign dsp_b     = dspB_q;
    assign dsp_d     = dspD_q;
    assign dsp_c     = dspC_q;
    assign rsp_valid = rspValid_q;
    assign rsp_p     = rspP_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_dsp_share_arb.sv
// Self-checking bench for dsp_share_arb: behavioural DSP, queue-based reference model, directed scenarios.
module tb_dsp_share_arb;

    localparam int NREQ    = 4;
    localparam int LATENCY = 4;

    logic                clk;
    logic                rst_n;
    logic                arb_en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*18-1:0]  req_a, req_b, req_d;
    logic [NREQ*48-1:0]  req_c;
    logic [17:0]         dsp_a, dsp_b, dsp_d;
    logic [47:0]         dsp_c;
    logic [47:0]         dsp_p;
    logic [NREQ-1:0]     rsp_valid;
    logic [47:0]         rsp_p;
    logic [3:0]          inflight;

    logic [17:0] opA [NREQ];
    logic [17:0] opB [NREQ];
    logic [17:0] opD [NREQ];
    logic [47:0] opC [NREQ];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int rspCount = 0;
    int grantLog [$];

    typedef struct {
        int          id;
        logic [47:0] p;
        int          due;
    } exp_t;
    exp_t        expQ [$];
    int          lastGrant = NREQ - 1;
    logic [47:0] lastP = '0;

    dsp_share_arb #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_d     (req_d),
        .req_c     (req_c),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_d     (dsp_d),
        .dsp_c     (dsp_c),
        .dsp_p     (dsp_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] golden(input logic [17:0] a, input logic [17:0] b,
                                           input logic [17:0] d, input logic [47:0] c);
        logic [17:0] s;
        s = b + d;
        return 48'(s) * 48'(a) + c;
    endfunction

    // Stand-in for the DSP slice: result appears LATENCY edges after the operands.
    logic [47:0] dspPipe [LATENCY];
    always @(posedge clk) begin
        dspPipe[0] <= golden(dsp_a, dsp_b, dsp_d, dsp_c);
        for (int k = 1; k < LATENCY; k++) begin
            dspPipe[k] <= dspPipe[k-1];
        end
    end
    assign dsp_p = dspPipe[LATENCY-1];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[18*i +: 18] = opA[i];
            req_b[18*i +: 18] = opB[i];
            req_d[18*i +: 18] = opD[i];
            req_c[48*i +: 48] = opC[i];
        end
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic e, input int cycles);
        req_valid = v;
        arb_en    = e;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: expected grant from round-robin rules, responses from a due-cycle queue.
    always @(negedge clk) begin
        int expGrant;
        logic [NREQ-1:0] expReady;
        logic [NREQ-1:0] expRsp;
        if (!rst_n) begin
            checkOutput("reset_req_ready", req_ready, 0);
            checkOutput("reset_rsp_valid", rsp_valid, 0);
            checkOutput("reset_rsp_p", rsp_p, 0);
            checkOutput("reset_inflight", inflight, 0);
            checkOutput("reset_dsp_a", dsp_a, 0);
            expQ.delete();
            lastGrant = NREQ - 1;
            lastP     = '0;
        end else begin
            expGrant = -1;
            if (arb_en) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (lastGrant + k) % NREQ;
                    if (expGrant < 0 && req_valid[i]) expGrant = i;
                end
            end
            expReady = (expGrant >= 0) ? NREQ'(1) << expGrant : '0;
            checkOutput("req_ready", req_ready, expReady);

            expRsp = '0;
            if (expQ.size() > 0 && expQ[0].due == cycle) begin
                expRsp = NREQ'(1) << expQ[0].id;
                lastP  = expQ[0].p;
            end
            checkOutput("rsp_valid", rsp_valid, expRsp);
            checkOutput("rsp_p", rsp_p, lastP);
            checkOutput("inflight", inflight, 64'(expQ.size()));
            if (expRsp != 0) void'(expQ.pop_front());
            if (rsp_valid != 0) rspCount++;

            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) grantLog.push_back(i);
            end
            if (expGrant >= 0) begin
                expQ.push_back('{id: expGrant,
                                 p: golden(opA[expGrant], opB[expGrant], opD[expGrant], opC[expGrant]),
                                 due: cycle + LATENCY + 2});
                lastGrant = expGrant;
            end
        end
    end

    task automatic singleOp(input int id, input logic [17:0] a, input logic [17:0] b,
                            input logic [17:0] d, input logic [47:0] c, input logic [47:0] expP);
        int hsCycle;
        bit seen;
        opA[id] = a;
        opB[id] = b;
        opD[id] = d;
        opC[id] = c;
        req_valid = NREQ'(1) << id;
        arb_en    = 1'b1;
        @(negedge clk);
        checkOutput("single_inflight_idle", inflight, 0);
        checkOutput("single_ready", req_ready, 64'(1) << id);
        @(posedge clk);
        #1;
        req_valid = '0;
        hsCycle   = cycle;
        @(negedge clk);
        checkOutput("single_inflight_busy", inflight, 1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (rsp_valid != 0) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("single_rsp_seen", 64'(seen), 1);
        if (seen) begin
            checkOutput("single_rsp_valid", rsp_valid, 64'(1) << id);
            checkOutput("single_rsp_p", rsp_p, expP);
            checkOutput("single_latency", 64'(cycle - hsCycle), LATENCY + 1);
        end
        @(negedge clk);
        checkOutput("single_rsp_drop", rsp_valid, 0);
        checkOutput("single_inflight_done", inflight, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fairOrder [8];
        fairOrder = '{0, 1, 2, 3, 0, 1, 2, 3};

        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 18'(i * 1000 + 11);
            opB[i] = 18'(i * 37 + 5);
            opD[i] = 18'(i * 101 + 9);
            opC[i] = 48'(i * 5000 + 77);
        end

        // Reset with every requester asking; nothing may be granted until release.
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grantLog.delete();
        @(negedge clk);
        checkOutput("first_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        applyStimulus(4'b1111, 1'b1, 7);
        applyStimulus(4'b0000, 1'b1, 12);
        checkOutput("fair_count", 64'(grantLog.size()), 8);
        for (int k = 0; k < 8 && k < grantLog.size(); k++) begin
            checkOutput($sformatf("fair_grant_%0d", k), 64'(grantLog[k]), 64'(fairOrder[k]));
        end
        checkOutput("fair_drained", inflight, 0);

        singleOp(2, 18'd3, 18'd5, 18'd7, 48'd100, 48'd136);
        singleOp(1, 18'd5, 18'h3FFFF, 18'd1, 48'd10, 48'd10);
        singleOp(3, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, 48'h000F_FFF4_0001);

        // Three ops go out, then grants stop while requesters 0 and 1 keep asking.
        opA[0] = 18'd21;  opB[0] = 18'd2;  opD[0] = 18'd3;  opC[0] = 48'd4;
        opA[1] = 18'd100; opB[1] = 18'd1;  opD[1] = 18'd1;  opC[1] = 48'd1;
        rspCount = 0;
        grantLog.delete();
        applyStimulus(4'b0011, 1'b1, 3);
        applyStimulus(4'b0011, 1'b0, 12);
        checkOutput("en_drop_grants", 64'(grantLog.size()), 3);
        checkOutput("en_drop_responses", 64'(rspCount), 3);
        checkOutput("en_drop_inflight", inflight, 0);
        applyStimulus(4'b0000, 1'b1, 1);

        // Three back-to-back ops, then a one-cycle reset before any result returns.
        applyStimulus(4'b1111, 1'b1, 3);
        req_valid = '0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rspCount = 0;
        applyStimulus(4'b0000, 1'b1, 12);
        checkOutput("reset_flush_pulses", 64'(rspCount), 0);
        checkOutput("reset_flush_inflight", inflight, 0);
        singleOp(2, 18'd3, 18'd5, 18'd7, 48'd100, 48'd136);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
